// File: rtl/clock_ctrl_pkg.sv
// Shared constants and state encoding for the century clock set controller.
package clock_ctrl_pkg;

   localparam int DEF_NUM_FIELDS = 6;

   localparam int FLD_SEC   = 0;
   localparam int FLD_MIN   = 1;
   localparam int FLD_HOUR  = 2;
   localparam int FLD_DAY   = 3;
   localparam int FLD_MONTH = 4;
   localparam int FLD_YEAR  = 5;

   // ST_SETk selects field k; the 3-bit encoding covers up to 7 fields.
   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_SET0 = 3'd1,
      ST_SET1 = 3'd2,
      ST_SET2 = 3'd3,
      ST_SET3 = 3'd4,
      ST_SET4 = 3'd5,
      ST_SET5 = 3'd6
   } state_t;

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Button edge detect with hold-to-repeat; fire is a 1-cycle pulse, registered by the caller.
module btn_repeat #(
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic clr,
   output logic level,
   output logic rise,
   output logic fire
);

   localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;

   logic          btn_q;
   logic          btn_prev;
   logic          armed;
   logic [CW-1:0] hold_cnt;

   assign level = btn_q;
   assign rise  = btn_q & ~btn_prev;

   // A press only arms on its own rising edge; clr disarms until the next one.
   always_comb begin
      fire = 1'b0;
      if (!clr)
         fire = rise || (armed && btn_q && (hold_cnt == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q    <= 1'b0;
         btn_prev <= 1'b0;
         armed    <= 1'b0;
         hold_cnt <= '0;
      end else begin
         btn_q    <= btn;
         btn_prev <= btn_q;
         if (clr || !btn_q) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
         end else if (rise) begin
            armed    <= 1'b1;
            hold_cnt <= CW'(REPEAT_DELAY - 1);
         end else if (armed) begin
            if (hold_cnt == '0)
               hold_cnt <= CW'(REPEAT_PERIOD - 1);
            else
               hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM, blink and inactivity timeout for the clock field set controller.
//   state   | meaning
//   ST_RUN  | counters run, no field selected
//   ST_SETk | counting frozen, field k selected for adjust
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int NUM_FIELDS    = DEF_NUM_FIELDS,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter int BLINK_HALF    = 12500000,
   parameter int TIMEOUT       = 500000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_mode,
   input  logic                  btn_up,
   input  logic                  btn_down,
   output logic                  run_en,
   output logic [NUM_FIELDS-1:0] sel,
   output logic [NUM_FIELDS-1:0] up_o,
   output logic [NUM_FIELDS-1:0] down_o,
   output logic                  blink
);

   localparam int BW = $clog2(BLINK_HALF) + 1;
   localparam int IW = $clog2(TIMEOUT) + 1;
   localparam logic [2:0] LAST_ST = 3'(NUM_FIELDS);

   state_t                state, state_nxt;
   logic                  mode_q, mode_prev, mode_rise;
   logic                  up_lvl, up_rise, up_fire;
   logic                  down_lvl, down_rise, down_fire;
   logic                  in_set, clr, activity, timeout, entering;
   logic [NUM_FIELDS-1:0] sel_nxt;
   logic [BW-1:0]         blink_cnt;
   logic [IW-1:0]         idle_left;

   assign mode_rise = mode_q & ~mode_prev;
   assign in_set    = (state != ST_RUN);
   // Both buttons down, a mode step, or RUN all block and disarm adjusts.
   assign clr       = !in_set || mode_rise || (up_lvl && down_lvl);
   assign activity  = mode_rise || up_rise || down_rise || up_fire || down_fire;
   assign timeout   = in_set && (idle_left == '0) && !activity;
   assign entering  = (state_nxt != ST_RUN) && (state_nxt != state);

   btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
      .clk(clk), .rst(rst), .btn(btn_up), .clr(clr),
      .level(up_lvl), .rise(up_rise), .fire(up_fire)
   );

   btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
      .clk(clk), .rst(rst), .btn(btn_down), .clr(clr),
      .level(down_lvl), .rise(down_rise), .fire(down_fire)
   );

   always_comb begin
      state_nxt = state;
      sel_nxt   = '0;
      if (mode_rise)
         state_nxt = (state == LAST_ST) ? ST_RUN : state_t'(state + 3'd1);
      else if (timeout)
         state_nxt = ST_RUN;
      if (state_nxt != ST_RUN)
         sel_nxt = NUM_FIELDS'(1) << (state_nxt - 3'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         mode_q    <= 1'b0;
         mode_prev <= 1'b0;
         run_en    <= 1'b1;
         sel       <= '0;
         up_o      <= '0;
         down_o    <= '0;
      end else begin
         state     <= state_nxt;
         mode_q    <= btn_mode;
         mode_prev <= mode_q;
         run_en    <= (state_nxt == ST_RUN);
         sel       <= sel_nxt;
         up_o      <= up_fire ? sel : '0;
         down_o    <= down_fire ? sel : '0;
      end
   end

   // Blink restarts visible on entry and on every adjust so the edited field never vanishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink     <= 1'b1;
         blink_cnt <= '0;
      end else if (state_nxt == ST_RUN) begin
         blink     <= 1'b1;
         blink_cnt <= '0;
      end else if (entering || up_fire || down_fire) begin
         blink     <= 1'b1;
         blink_cnt <= BW'(BLINK_HALF - 1);
      end else if (blink_cnt == '0) begin
         blink     <= ~blink;
         blink_cnt <= BW'(BLINK_HALF - 1);
      end else begin
         blink_cnt <= blink_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         idle_left <= IW'(TIMEOUT - 1);
      else if ((state_nxt == ST_RUN) || activity)
         idle_left <= IW'(TIMEOUT - 1);
      else if (idle_left != '0)
         idle_left <= idle_left - 1'b1;
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short repeat/blink/timeout parameters.
module tb_clock_set_ctrl;

   localparam int NF = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_mode = 1'b0;
   logic          btn_up = 1'b0;
   logic          btn_down = 1'b0;
   logic          run_en;
   logic          blink;
   logic [NF-1:0] sel;
   logic [NF-1:0] up_o;
   logic [NF-1:0] down_o;

   int checks = 0;
   int failures = 0;

   clock_set_ctrl #(
      .NUM_FIELDS(NF), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .BLINK_HALF(5), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .run_en(run_en), .sel(sel), .up_o(up_o), .down_o(down_o), .blink(blink)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      rst      = 1'b1;
      step();
      step();
      rst      = 1'b0;
   endtask

   task automatic mode_pulse();
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
      step();
   endtask

   task automatic goto_set(input int k);
      do_reset();
      for (int p = 0; p <= k; p++) mode_pulse();
   endtask

   initial begin
      logic [NF-1:0] one;
      logic [NF-1:0] exp_sel;
      logic [NF-1:0] exp_dn;
      logic [NF-1:0] exp_up;
      one = 6'd1;

      // Reset state
      do_reset();
      chk("rst_run_en", 32'(run_en), 32'd1);
      chk("rst_sel",    32'(sel),    32'd0);
      chk("rst_up",     32'(up_o),   32'd0);
      chk("rst_down",   32'(down_o), 32'd0);
      chk("rst_blink",  32'(blink),  32'd1);

      // 1: seven mode pulses walk the fields and come back to RUN
      for (int k = 0; k < 7; k++) begin
         mode_pulse();
         exp_sel = (k < 6) ? (one << k) : 6'd0;
         chk("mode_sel",    32'(sel),    32'(exp_sel));
         chk("mode_run_en", 32'(run_en), (k < 6) ? 32'd0 : 32'd1);
      end

      // 2: single up press in SET_4
      goto_set(4);
      chk("set4_sel", 32'(sel), 32'h10);
      btn_up = 1'b1;
      step();
      btn_up = 1'b0;
      chk("up_early", 32'(up_o), 32'd0);
      step();
      chk("up_pulse",   32'(up_o),   32'h10);
      chk("up_no_down", 32'(down_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("up_after", 32'(up_o), 32'd0);
      end

      // mode and up rising together: mode wins, no strobe
      btn_mode = 1'b1;
      btn_up   = 1'b1;
      step();
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      step();
      chk("modewin_sel", 32'(sel),  32'h20);
      chk("modewin_up0", 32'(up_o), 32'd0);
      step();
      chk("modewin_up1", 32'(up_o), 32'd0);

      // 3: down held 20 cycles in SET_0
      goto_set(0);
      btn_down = 1'b1;
      step();
      for (int i = 1; i <= 24; i++) begin
         if (i == 20) btn_down = 1'b0;
         step();
         exp_dn = (i == 1 || i == 9 || i == 13 || i == 17) ? 6'h01 : 6'h00;
         chk("hold_down", 32'(down_o), 32'(exp_dn));
         chk("hold_down_up", 32'(up_o), 32'd0);
      end

      // 4: both pressed in SET_2, then release down
      goto_set(2);
      btn_up   = 1'b1;
      btn_down = 1'b1;
      step();
      for (int i = 1; i <= 10; i++) begin
         step();
         chk("both_up",   32'(up_o),   32'd0);
         chk("both_down", 32'(down_o), 32'd0);
      end
      btn_down = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("one_left_up", 32'(up_o), 32'd0);
      end
      btn_up = 1'b0;
      step();
      btn_up = 1'b1;
      step();
      step();
      chk("repress_up", 32'(up_o), 32'h04);
      btn_up = 1'b0;

      // 5: idle in SET_1, blink cadence then timeout
      goto_set(1);
      chk("idle_sel0",   32'(sel),   32'h02);
      chk("idle_blink0", 32'(blink), 32'd1);
      for (int t = 1; t <= 64; t++) begin
         step();
         if (t < 64) begin
            chk("idle_blink", 32'(blink), (((t / 5) % 2) == 0) ? 32'd1 : 32'd0);
            chk("idle_sel",   32'(sel),   32'h02);
         end else begin
            chk("tmo_sel",    32'(sel),    32'd0);
            chk("tmo_run_en", 32'(run_en), 32'd1);
            chk("tmo_blink",  32'(blink),  32'd1);
         end
      end

      // 6: reset in the middle of an up repeat in SET_3
      goto_set(3);
      btn_up = 1'b1;
      step();
      for (int i = 1; i <= 10; i++) begin
         step();
         exp_up = (i == 1 || i == 9) ? 6'h08 : 6'h00;
         chk("rep_up", 32'(up_o), 32'(exp_up));
      end
      rst = 1'b1;
      step();
      chk("midrst_run_en", 32'(run_en), 32'd1);
      chk("midrst_sel",    32'(sel),    32'd0);
      chk("midrst_up",     32'(up_o),   32'd0);
      chk("midrst_down",   32'(down_o), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("postrst_up", 32'(up_o), 32'd0);
      end
      mode_pulse();
      chk("postrst_sel", 32'(sel), 32'h01);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("held_set0_up", 32'(up_o), 32'd0);
      end
      btn_up = 1'b0;
      step();
      btn_up = 1'b1;
      step();
      step();
      chk("new_edge_up", 32'(up_o), 32'h01);
      btn_up = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
